// File: rtl/press_arb_pkg.sv
// Shared types and default sizing for the push-button request arbiter.
// Optional PRESS_ARB_DEBOUNCE_EN adds per-line debounce counters.
package press_arb_pkg;

  localparam int N_DEF    = 4;
  localparam int SYNC_DEF = 2;
  localparam int DEB_DEF  = 1000;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/press_arbiter_if.sv
// Grant handshake between the arbiter (master) and its single consumer.
// grant_idx stays stable while grant_valid is high and unaccepted.
interface press_arbiter_if
  import press_arb_pkg::*;
#(
  parameter int N = N_DEF
);

  localparam int IW = $clog2(N);

  logic          grant_valid;
  logic          grant_ready;
  logic [IW-1:0] grant_idx;

  modport master (
    output grant_valid,
    output grant_idx,
    input  grant_ready
  );

  modport slave (
    input  grant_valid,
    input  grant_idx,
    output grant_ready
  );

endinterface

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer for an asynchronous raw input.
// All flops clear on reset so a held-high line yields a fresh edge.
module sync_chain
  import press_arb_pkg::*;
#(
  parameter int STAGES = SYNC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/press_arbiter.sv
// Sync, edge-latch and round-robin hand-off of N raw request lines.
// Define PRESS_ARB_DEBOUNCE_EN to insert debounce counters per line.
module press_arbiter
  import press_arb_pkg::*;
#(
  parameter int N               = N_DEF,
  parameter int SYNC_STAGES     = SYNC_DEF,
  parameter int DEBOUNCE_CYCLES = DEB_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_raw,
  press_arbiter_if.master gnt,
  output logic [N-1:0]    pending,
  output logic            overflow
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 16 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("press_arbiter: parameter out of range");
  end

  logic [N-1:0] s;
  logic [N-1:0] lvl;
  logic [N-1:0] lvl_dly_q;
  logic [N-1:0] rise;

`ifdef PRESS_ARB_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`endif

  for (genvar g = 0; g < N; g++) begin : g_line
    sync_chain #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (req_raw[g]),
      .q_o   (s[g])
    );

`ifdef PRESS_ARB_DEBOUNCE_EN
    logic [CW-1:0] cnt_q;
    logic          deb_q;

    // any sample matching the accepted level restarts the count
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (s[g] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        deb_q <= s[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign lvl[g] = deb_q;
`else
    assign lvl[g] = s[g];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_dly_q <= '0;
    end else begin
      lvl_dly_q <= lvl;
    end
  end

  assign rise = lvl & ~lvl_dly_q;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic [IW-1:0] win;
  logic          found;
  int            k;

  assign accept = (state_q == OFFER) && gnt.grant_ready;

  // first pending line at or after ptr, wrapping modulo N
  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = 0;
    for (int j = 0; j < N; j++) begin
      k = int'(ptr_q) + j;
      if (k >= N) k = k - N;
      if (!found && pend_q[k[IW-1:0]]) begin
        found = 1'b1;
        win   = k[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < N; i++) begin
      if (accept && idx_q == IW'(i)) begin
        pend_d[i] = rise[i];
      end else if (rise[i]) begin
        if (pend_q[i]) ovf_d = 1'b1;
        pend_d[i] = 1'b1;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          idx_d   = win;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (gnt.grant_ready) begin
          ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign gnt.grant_valid = (state_q == OFFER);
  assign gnt.grant_idx   = idx_q;
  assign pending         = pend_q;
  assign overflow        = ovf_q;

endmodule
